// File: rtl/obstacle_pkg.sv
// Shared constants for the obstacle subsystem: playfield geometry, LFSR taps,
// spawner state encoding and the per-trigger movement step.
package obstacle_pkg;

  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int OBSTACLE_SIZE_X = 32;
  localparam int OBSTACLE_SIZE_Y = 32;
  localparam int OBSTACLE_STEP   = 4;

  // x^10 + x^7 + 1: feedback taps on bits 9 and 6
  localparam logic [9:0] LFSR_TAPS = 10'h240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } spawn_state_e;

  // max(minp, base - lvl*step), evaluated wide so the floor wins before any wrap
  function automatic logic [23:0] period_calc(input logic [23:0] base,
                                              input logic [23:0] step,
                                              input logic [23:0] minp,
                                              input logic [3:0]  lvl);
    logic [28:0] red;
    red = 29'(lvl) * 29'(step);
    if (29'(base) <= (29'(minp) + red)) return minp;
    return base - red[23:0];
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR; a zero state (illegal lock-up) reloads the seed.
module lfsr10
  import obstacle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] seed,
  output logic [9:0] q
);

  logic [9:0] q_q;
  logic [9:0] q_d;

  always_comb begin
    q_d = {q_q[8:0], ^(q_q & LFSR_TAPS)};
    if (q_q == 10'd0) q_d = seed;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Paces the obstacle movement controller with trigger pulses, picks start x on
// each fall and tracks spawns/difficulty. Speed-up gated by OBSTACLE_SPEEDUP_EN.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int          SCREEN_W         = obstacle_pkg::SCREEN_W,
  parameter int          SIZE_X           = obstacle_pkg::OBSTACLE_SIZE_X,
  parameter logic [9:0]  START_Y          = 10'd0,
  parameter logic [23:0] BASE_PERIOD      = 24'd833333,
  parameter logic [23:0] PERIOD_STEP      = 24'd50000,
  parameter logic [23:0] MIN_PERIOD       = 24'd200000,
  parameter logic [23:0] ARM_DELAY        = 24'd1000000,
  parameter int          SPAWNS_PER_LEVEL = 8,
  parameter int          MAX_LEVEL        = 15,
  parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [9:0]   obstacle_y,
  output logic         obstacle_trigger,
  output logic [9:0]   obstacle_start_x,
  output logic [9:0]   obstacle_start_y,
  output logic [3:0]   level,
  output logic [15:0]  spawn_count,
  output spawn_state_e dbg_state
);

  localparam logic [9:0]  X_MAX   = 10'(SCREEN_W - SIZE_X);
  localparam logic [9:0]  X_RST   = 10'(SCREEN_W / 2 - SIZE_X / 2);
  localparam logic [3:0]  LVL_MAX = 4'(MAX_LEVEL);
  localparam logic [15:0] SPL_TC  = 16'(SPAWNS_PER_LEVEL - 1);
`ifdef OBSTACLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  spawn_state_e state_q, state_d;
  logic [23:0]  cnt_q, cnt_d;
  logic         trig_q, trig_d;
  logic [9:0]   start_x_q, start_x_d;
  logic [3:0]   level_q, level_d;
  logic [15:0]  spawn_q, spawn_d;
  logic [15:0]  wrap_cnt_q, wrap_cnt_d;
  logic [9:0]   y_prev_q;
  logic [9:0]   lfsr_q;
  logic [9:0]   cand;
  logic [23:0]  period;
  logic         wrap;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // A single conditional subtract folds 609..1023 back into 0..414
  always_comb begin
    cand = lfsr_q;
    if (lfsr_q > X_MAX) cand = lfsr_q - (X_MAX + 10'd1);
  end

  assign period = period_calc(BASE_PERIOD, PERIOD_STEP, MIN_PERIOD, level_q);
  assign wrap   = (state_q == RUN) && (obstacle_y < y_prev_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_d     = 1'b0;
    start_x_d  = start_x_q;
    level_d    = level_q;
    spawn_d    = spawn_q;
    wrap_cnt_d = wrap_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d   = ARM;
          start_x_d = cand;
        end
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= ARM_DELAY - 24'd1) begin
          trig_d  = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      RUN, PAUSE: begin
        // Count only on enabled cycles, so a pause stretches the interval exactly
        if (!enable) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
          if (cnt_q >= period - 24'd1) begin
            trig_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wrap) begin
      start_x_d = cand;
      if (spawn_q != 16'hFFFF) spawn_d = spawn_q + 16'd1;
      if (wrap_cnt_q >= SPL_TC) begin
        wrap_cnt_d = '0;
        if (SPEEDUP && (level_q < LVL_MAX)) level_d = level_q + 4'd1;
      end else begin
        wrap_cnt_d = wrap_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      start_x_q  <= X_RST;
      level_q    <= '0;
      spawn_q    <= '0;
      wrap_cnt_q <= '0;
      y_prev_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      start_x_q  <= start_x_d;
      level_q    <= level_d;
      spawn_q    <= spawn_d;
      wrap_cnt_q <= wrap_cnt_d;
      y_prev_q   <= obstacle_y;
    end
  end

  assign obstacle_trigger = trig_q;
  assign obstacle_start_x = start_x_q;
  assign obstacle_start_y = START_Y;
  assign level            = level_q;
  assign spawn_count      = spawn_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner with short periods (base 10, arm 5).
`timescale 1ns/1ps
module tb_obstacle_spawner;
  import obstacle_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [9:0]   obstacle_y;
  logic         obstacle_trigger;
  logic [9:0]   obstacle_start_x;
  logic [9:0]   obstacle_start_y;
  logic [3:0]   level;
  logic [15:0]  spawn_count;
  spawn_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_trig;
  int exp_spawn;

  logic [9:0]  mdl_lfsr;
  logic [9:0]  exp_q[$];
  logic [31:0] trig_q[$];

  always #5 clk = ~clk;

  obstacle_spawner #(
    .BASE_PERIOD (24'd10),
    .PERIOD_STEP (24'd2),
    .MIN_PERIOD  (24'd4),
    .ARM_DELAY   (24'd5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .obstacle_y       (obstacle_y),
    .obstacle_trigger (obstacle_trigger),
    .obstacle_start_x (obstacle_start_x),
    .obstacle_start_y (obstacle_start_y),
    .level            (level),
    .spawn_count      (spawn_count),
    .dbg_state        (dbg_state)
  );

  // Reference LFSR: x^10+x^7+1, seed 0x2A5
  always @(posedge clk) begin
    if (reset)                 mdl_lfsr <= 10'h2A5;
    else if (mdl_lfsr == 10'd0) mdl_lfsr <= 10'h2A5;
    else                       mdl_lfsr <= {mdl_lfsr[8:0], mdl_lfsr[9] ^ mdl_lfsr[6]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [9:0] map_x(input logic [9:0] v);
    return (v > 10'd608) ? v - 10'd609 : v;
  endfunction

  function automatic int exp_period(input int lvl);
`ifdef OBSTACLE_SPEEDUP_EN
    int p;
    p = 10 - 2 * lvl;
    return (p < 4) ? 4 : p;
`else
    return 10;
`endif
  endfunction

  function automatic int exp_level(input int spawns);
`ifdef OBSTACLE_SPEEDUP_EN
    return (spawns / 8 > 15) ? 15 : spawns / 8;
`else
    return 0;
`endif
  endfunction

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; obstacle_y = 10'd0;
    tick; tick;
    total++; if (obstacle_trigger !== 1'b0) begin bad++; $display("FAIL reset_trig: got %0b want 0", obstacle_trigger); end
    total++; if (obstacle_start_x !== 10'd304) begin bad++; $display("FAIL reset_start_x: got %0d want 304", obstacle_start_x); end
    total++; if (obstacle_start_y !== 10'd0) begin bad++; $display("FAIL reset_start_y: got %0d want 0", obstacle_start_y); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (spawn_count !== 16'd0) begin bad++; $display("FAIL reset_spawn: got %0d want 0", spawn_count); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    reset = 1'b0;
    tick;
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL idle_hold: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_arm_run;
    logic [9:0]  x;
    logic [31:0] t;
    int c0;
    exp_q.push_back(map_x(mdl_lfsr));
    enable = 1'b1;
    tick;
    c0 = cyc;
    total++; if (dbg_state !== ARM) begin bad++; $display("FAIL arm_state: got %0d want ARM", dbg_state); end
    x = exp_q.pop_front();
    total++; if (obstacle_start_x !== x) begin bad++; $display("FAIL arm_start_x: got %0d want %0d", obstacle_start_x, x); end
    trig_q.push_back(32'(c0 + 5));
    trig_q.push_back(32'(c0 + 15));
    trig_q.push_back(32'(c0 + 25));
    for (int i = 0; i < 27; i++) begin
      tick;
      if (obstacle_trigger === 1'b1) begin
        total++;
        if (trig_q.size() == 0) begin
          bad++; $display("FAIL run_trig: unexpected pulse at cycle %0d", cyc);
        end else begin
          t = trig_q.pop_front();
          if (32'(cyc) !== t) begin bad++; $display("FAIL run_trig: pulse at cycle %0d want %0d", cyc, t); end
        end
      end
    end
    total++; if (trig_q.size() != 0) begin bad++; $display("FAIL run_trig_missing: got %0d left want 0", trig_q.size()); trig_q.delete(); end
    total++; if (dbg_state !== RUN) begin bad++; $display("FAIL run_state: got %0d want RUN", dbg_state); end
    last_trig = c0 + 25;
  endtask

  task automatic test_pause;
    logic [31:0] t;
    trig_q.push_back(32'(last_trig + 17));
    trig_q.push_back(32'(last_trig + 27));
    for (int i = 0; i < 27; i++) begin
      enable = (i >= 1 && i < 8) ? 1'b0 : 1'b1;
      tick;
      if (i == 7) begin
        total++; if (dbg_state !== PAUSE) begin bad++; $display("FAIL pause_state: got %0d want PAUSE", dbg_state); end
      end
      if (obstacle_trigger === 1'b1) begin
        total++;
        if (trig_q.size() == 0) begin
          bad++; $display("FAIL pause_trig: unexpected pulse at cycle %0d", cyc);
        end else begin
          t = trig_q.pop_front();
          if (32'(cyc) !== t) begin bad++; $display("FAIL pause_trig: pulse at cycle %0d want %0d", cyc, t); end
        end
      end
    end
    total++; if (trig_q.size() != 0) begin bad++; $display("FAIL pause_trig_missing: got %0d left want 0", trig_q.size()); trig_q.delete(); end
  endtask

  task automatic test_wrap;
    logic [9:0] x;
    exp_spawn = 0;
    obstacle_y = 10'd444; tick;
    obstacle_y = 10'd448; tick;
    total++; if (spawn_count !== 16'd0) begin bad++; $display("FAIL wrap_rise: got %0d want 0", spawn_count); end
    exp_q.push_back(map_x(mdl_lfsr));
    obstacle_y = 10'd0; tick;
    exp_spawn++;
    x = exp_q.pop_front();
    total++; if (obstacle_start_x !== x) begin bad++; $display("FAIL wrap_start_x: got %0d want %0d", obstacle_start_x, x); end
    total++; if (obstacle_start_x > 10'd608) begin bad++; $display("FAIL wrap_x_range: got %0d want <=608", obstacle_start_x); end
    total++; if (spawn_count !== 16'(exp_spawn)) begin bad++; $display("FAIL wrap_spawn: got %0d want %0d", spawn_count, exp_spawn); end
  endtask

  task automatic test_wrap_paused;
    logic [9:0] x0;
    obstacle_y = 10'd500; tick;
    enable = 1'b0; tick;
    x0 = obstacle_start_x;
    obstacle_y = 10'd10; tick;
    total++; if (spawn_count !== 16'(exp_spawn)) begin bad++; $display("FAIL paused_wrap_spawn: got %0d want %0d", spawn_count, exp_spawn); end
    total++; if (obstacle_start_x !== x0) begin bad++; $display("FAIL paused_wrap_x: got %0d want %0d", obstacle_start_x, x0); end
    enable = 1'b1; tick;
  endtask

  task automatic test_levels;
    int targets[3] = '{8, 32, 136};
    int p;
    int c;
    bit found;
    logic [31:0] t;
    for (int s = 0; s < 3; s++) begin
      while (exp_spawn < targets[s]) begin
        obstacle_y = 10'd200; tick;
        obstacle_y = 10'd100; tick;
        exp_spawn++;
      end
      total++; if (spawn_count !== 16'(exp_spawn)) begin bad++; $display("FAIL lvl_spawn: got %0d want %0d", spawn_count, exp_spawn); end
      total++; if (level !== 4'(exp_level(exp_spawn))) begin bad++; $display("FAIL lvl_level: got %0d want %0d", level, exp_level(exp_spawn)); end
      p = exp_period(exp_level(exp_spawn));
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        tick;
        if (obstacle_trigger === 1'b1) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL lvl_sync: got no pulse in 30 cycles want one");
      end else begin
        c = cyc;
        trig_q.push_back(32'(c + p));
        trig_q.push_back(32'(c + 2 * p));
        for (int i = 0; i < 2 * p + 1; i++) begin
          tick;
          if (obstacle_trigger === 1'b1) begin
            total++;
            if (trig_q.size() == 0) begin
              bad++; $display("FAIL lvl_period: unexpected pulse at cycle %0d", cyc);
            end else begin
              t = trig_q.pop_front();
              if (32'(cyc) !== t) begin bad++; $display("FAIL lvl_period: pulse at cycle %0d want %0d (period %0d)", cyc, t, p); end
            end
          end
        end
        total++; if (trig_q.size() != 0) begin bad++; $display("FAIL lvl_period_missing: got %0d left want 0", trig_q.size()); trig_q.delete(); end
      end
    end
  endtask

  task automatic test_lfsr_sweep;
    logic [9:0] v0;
    int first_ret;
    v0 = dut.lfsr_q;
    first_ret = 0;
    for (int i = 1; i <= 1023; i++) begin
      tick;
      total++; if (dut.lfsr_q !== mdl_lfsr) begin bad++; $display("FAIL lfsr_seq: got %h want %h", dut.lfsr_q, mdl_lfsr); end
      total++; if (dut.lfsr_q === 10'd0) begin bad++; $display("FAIL lfsr_zero: got 0 want nonzero"); end
      total++; if (dut.cand !== map_x(mdl_lfsr) || dut.cand > 10'd608) begin bad++; $display("FAIL lfsr_cand: got %0d want %0d", dut.cand, map_x(mdl_lfsr)); end
      if (dut.lfsr_q === v0 && first_ret == 0) first_ret = i;
    end
    total++; if (first_ret != 1023) begin bad++; $display("FAIL lfsr_period: got %0d want 1023", first_ret); end
  endtask

  task automatic test_reset_during_trigger;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick;
      if (obstacle_trigger === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rst_sync: got no pulse in 30 cycles want one"); end
    reset = 1'b1;
    tick;
    total++; if (obstacle_trigger !== 1'b0) begin bad++; $display("FAIL rst_trig: got %0b want 0", obstacle_trigger); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    total++; if (spawn_count !== 16'd0) begin bad++; $display("FAIL rst_spawn: got %0d want 0", spawn_count); end
    total++; if (obstacle_start_x !== 10'd304) begin bad++; $display("FAIL rst_start_x: got %0d want 304", obstacle_start_x); end
    total++; if (dut.lfsr_q !== 10'h2A5) begin bad++; $display("FAIL rst_lfsr: got %h want 2a5", dut.lfsr_q); end
    reset = 1'b0; enable = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_arm_run;
    test_pause;
    test_wrap;
    test_wrap_paused;
    test_levels;
    test_lfsr_sweep;
    test_reset_during_trigger;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
